// File: rtl/peak_scan_ctrl_pkg.sv
// peak_scan_pkg: shared types, default widths and the signed-compare helper
// for the peak/maximum scan controller.
//   state_e    : controller states
//   cmp_e      : three-way compare result
//   cmp_signed : signed three-way compare on sign-extended operands
package peak_scan_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 9;
    localparam int NUM_W_DEF  = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CMP_LT,
        CMP_EQ,
        CMP_GT
    } cmp_e;

    // Callers sign-extend to int first, so no width-dependent wrap can occur.
    function automatic cmp_e cmp_signed(input int a, input int b);
        cmp_e r;
        if (a < b) begin
            r = CMP_LT;
        end else if (a > b) begin
            r = CMP_GT;
        end else begin
            r = CMP_EQ;
        end
        return r;
    endfunction

endpackage

// File: rtl/peak_scan_ctrl_if.sv
// peak_scan_ctrl_if: host-side bundle of the peak scan controller.
//   master : host (drives START/ABORT/write port, observes status/results)
//   slave  : controller
interface peak_scan_ctrl_if
    import peak_scan_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_W  = NUM_W_DEF
);
    logic              START;
    logic              ABORT;
    logic              WR_REQ;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic              WR_ACK;
    logic              BUSY;
    logic              DONE;
    logic              VALID;
    logic [DATA_W-1:0] MAX_OUT;
    logic [NUM_W-1:0]  NUM_OUT;

    modport master (
        output START, ABORT, WR_REQ, WR_ADDR, WR_DATA,
        input  WR_ACK, BUSY, DONE, VALID, MAX_OUT, NUM_OUT
    );

    modport slave (
        input  START, ABORT, WR_REQ, WR_ADDR, WR_DATA,
        output WR_ACK, BUSY, DONE, VALID, MAX_OUT, NUM_OUT
    );
endinterface

// File: rtl/peak_scan_ctrl_scan_mem.sv
// scan_mem: 2^ADDR_W x DATA_W single-port register file.
//   clk, rst : clock, asynchronous active-high clear of every word
//   we       : write enable (commits at the rising edge)
//   addr     : shared read/write address
//   wdata    : write data
//   rdata    : asynchronous read data at addr
module scan_mem #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[addr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[addr];
endmodule

// File: rtl/peak_scan_ctrl.sv
// peak_scan_ctrl: sequencer for a signed-maximum / peak-count scan over
// scan_mem, plus the alternating-priority arbiter sharing the memory port
// between host writes and scan reads.
//   CLOCK, RESET : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : START/ABORT, host write port with combinational WR_ACK,
//                  BUSY/DONE/VALID status, MAX_OUT/NUM_OUT results
//
// state   | meaning
// IDLE    | waiting for START, results held
// LOAD    | read address 0, seed MAX/TEMP, clear peak count
// SCAN    | one address per granted read
// DONE    | one-cycle completion, results just loaded
module peak_scan_ctrl
    import peak_scan_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_W  = NUM_W_DEF
) (
    input logic             CLOCK,
    input logic             RESET,
    peak_scan_ctrl_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [NUM_W-1:0]  NUM_MAX   = '1;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        mar_q, mar_d;
    logic signed [DATA_W-1:0] temp_q, temp_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic signed [DATA_W-1:0] max_out_q, max_out_d;
    logic [NUM_W-1:0]         num_q, num_d;
    logic [NUM_W-1:0]         num_out_q, num_out_d;
    logic                     flag_q, flag_d;
    logic                     valid_q, valid_d;
    logic                     host_last_q, host_last_d;

    logic                     busy;
    logic                     wr_ack;
    logic                     scan_go;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        rd_data;
    logic signed [DATA_W-1:0] rd_s;

    assign busy     = (state_q == ST_LOAD) || (state_q == ST_SCAN);
    // Outside a scan the host always wins; during a scan it wins only if it
    // did not own the port last cycle, bounding scan stalls to one cycle.
    assign wr_ack   = bus.WR_REQ && (!busy || !host_last_q);
    assign scan_go  = busy && !wr_ack;
    assign mem_addr = wr_ack ? bus.WR_ADDR : ((state_q == ST_LOAD) ? '0 : mar_q);
    assign rd_s     = $signed(rd_data);

    scan_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_scan_mem (
        .clk   (CLOCK),
        .rst   (RESET),
        .we    (wr_ack),
        .addr  (mem_addr),
        .wdata (bus.WR_DATA),
        .rdata (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        mar_d       = mar_q;
        temp_d      = temp_q;
        max_d       = max_q;
        num_d       = num_q;
        flag_d      = flag_q;
        max_out_d   = max_out_q;
        num_out_d   = num_out_q;
        valid_d     = valid_q;
        host_last_d = wr_ack;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.START) begin
                    state_d = ST_LOAD;
                    valid_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.ABORT) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (scan_go) begin
                    max_d   = rd_s;
                    temp_d  = rd_s;
                    flag_d  = 1'b0;
                    num_d   = '0;
                    mar_d   = ADDR_W'(1);
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bus.ABORT) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (scan_go) begin
                    case (cmp_signed(int'(rd_s), int'(temp_q)))
                        CMP_LT: begin
                            if (flag_q) begin
                                if (num_q != NUM_MAX) begin
                                    num_d = num_q + NUM_W'(1);
                                end
                                flag_d = 1'b0;
                            end
                        end
                        CMP_GT: begin
                            flag_d = 1'b1;
                            if (cmp_signed(int'(rd_s), int'(max_q)) == CMP_GT) begin
                                max_d = rd_s;
                            end
                        end
                        default: begin
                        end
                    endcase
                    temp_d = rd_s;
                    mar_d  = mar_q + ADDR_W'(1);
                    // Results include this final sample's update.
                    if (mar_q == LAST_ADDR) begin
                        state_d   = ST_DONE;
                        valid_d   = 1'b1;
                        max_out_d = max_d;
                        num_out_d = num_d;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            mar_q       <= '0;
            temp_q      <= '0;
            max_q       <= '0;
            num_q       <= '0;
            flag_q      <= 1'b0;
            max_out_q   <= '0;
            num_out_q   <= '0;
            valid_q     <= 1'b0;
            host_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            temp_q      <= temp_d;
            max_q       <= max_d;
            num_q       <= num_d;
            flag_q      <= flag_d;
            max_out_q   <= max_out_d;
            num_out_q   <= num_out_d;
            valid_q     <= valid_d;
            host_last_q <= host_last_d;
        end
    end

    assign bus.WR_ACK  = wr_ack;
    assign bus.BUSY    = busy;
    assign bus.DONE    = (state_q == ST_DONE);
    assign bus.VALID   = valid_q;
    assign bus.MAX_OUT = max_out_q;
    assign bus.NUM_OUT = num_out_q;
endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Testbench for peak_scan_ctrl: table-driven memory patterns, hand-written
// abort/restart/reset sequences, and randomized contention checked against a
// reference that folds over the sequence of values actually read.
module tb_peak_scan_ctrl;
    localparam int DEPTH = 32;

    logic CLOCK = 1'b0;
    logic RESET;
    always #5 CLOCK = ~CLOCK;

    peak_scan_ctrl_if bus ();
    peak_scan_ctrl dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] mdl  [DEPTH];
    logic [8:0] seen [DEPTH];
    bit host_prev;

    typedef struct {
        logic [8:0] base;
        bit         ramp;
        int         a0; logic [8:0] v0;
        int         a1; logic [8:0] v1;
        int         a2; logic [8:0] v2;
        logic [8:0] exp_max;
        logic [4:0] exp_num;
    } vec_t;
    vec_t vecs [7];

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int sval(input logic [8:0] x);
        logic signed [8:0] s;
        s = x;
        return int'(s);
    endfunction

    // Max is the global maximum; a peak is a rising step later followed by
    // a falling step (plateaus in between do not break it).
    function automatic void ref_result(output logic [8:0] mx, output logic [4:0] nm);
        int best, prev, cnt, v;
        bit up;
        best = sval(seen[0]); prev = best; cnt = 0; up = 0;
        for (int i = 1; i < DEPTH; i++) begin
            v = sval(seen[i]);
            if (v > best) best = v;
            if (v > prev) up = 1;
            else if (v < prev && up) begin cnt++; up = 0; end
            prev = v;
        end
        if (cnt > 31) cnt = 31;
        mx = 9'(best);
        nm = 5'(cnt);
    endfunction

    task automatic write_word(input logic [4:0] a, input logic [8:0] d);
        bus.WR_REQ = 1'b1; bus.WR_ADDR = a; bus.WR_DATA = d;
        #1;
        check("wr_ack_idle", int'(bus.WR_ACK), 1);
        mdl[a] = d; host_prev = 1;
        @(negedge CLOCK);
        bus.WR_REQ = 1'b0;
    endtask

    // Entered at cycle 1 (LOAD); returns at the negedge after DONE.
    task automatic scan_body(input int wr_pct, input bit fixed0, input bit restart, output int cyc);
        int reads;
        int c;
        logic req, exp_ack;
        logic [4:0] wa;
        logic [8:0] wd, emax;
        logic [4:0] enm;
        reads = 0; c = 1;
        while (reads < DEPTH && c < 300) begin
            req = ($urandom_range(1, 100) <= wr_pct);
            wa  = fixed0 ? 5'd0 : 5'($urandom);
            wd  = fixed0 ? 9'd0 : 9'($urandom);
            bus.START = ($urandom_range(0, 3) == 0);
            bus.ABORT = 1'b0;
            bus.WR_REQ = req; bus.WR_ADDR = wa; bus.WR_DATA = wd;
            #1;
            exp_ack = req && !host_prev;
            check("busy", int'(bus.BUSY), 1);
            check("done_early", int'(bus.DONE), 0);
            check("valid_in_scan", int'(bus.VALID), 0);
            check("wr_ack", int'(bus.WR_ACK), int'(exp_ack));
            if (exp_ack) begin
                mdl[wa] = wd; host_prev = 1;
            end else begin
                seen[reads] = mdl[reads]; reads++; host_prev = 0;
            end
            @(negedge CLOCK);
            c++;
        end
        bus.START = restart; bus.WR_REQ = 1'b0;
        #1;
        check("scan_timeout", int'(reads == DEPTH), 1);
        ref_result(emax, enm);
        check("done_pulse", int'(bus.DONE), 1);
        check("valid_done", int'(bus.VALID), 1);
        check("busy_done", int'(bus.BUSY), 0);
        check("max_out", int'(bus.MAX_OUT), int'(emax));
        check("num_out", int'(bus.NUM_OUT), int'(enm));
        host_prev = 0;
        cyc = c;
        @(negedge CLOCK);
        bus.START = 1'b0;
    endtask

    task automatic run_scan(input int wr_pct, input bit fixed0, input bit abort_too,
                            input bit restart, output int cyc);
        bus.START = 1'b1; bus.ABORT = abort_too; bus.WR_REQ = 1'b0;
        #1;
        check("start_no_ack", int'(bus.WR_ACK), 0);
        host_prev = 0;
        @(negedge CLOCK);
        bus.START = 1'b0; bus.ABORT = 1'b0;
        scan_body(wr_pct, fixed0, restart, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc, dones;
        logic [8:0] w;

        vecs[0] = '{9'h000, 1'b0,  0, 9'h005,  1, 9'h00A,  2, 9'h003, 9'h00A, 5'd1};
        vecs[1] = '{9'h1F9, 1'b0,  4, 9'h1FE, -1, 9'h000, -1, 9'h000, 9'h1FE, 5'd1};
        vecs[2] = '{9'h000, 1'b1, -1, 9'h000, -1, 9'h000, -1, 9'h000, 9'h01F, 5'd0};
        vecs[3] = '{9'h100, 1'b0, 31, 9'h0FF, -1, 9'h000, -1, 9'h000, 9'h0FF, 5'd0};
        vecs[4] = '{9'h000, 1'b0,  0, 9'h0FF,  1, 9'h100,  2, 9'h0FF, 9'h0FF, 5'd1};
        vecs[5] = '{9'h100, 1'b0, 10, 9'h0FF, 20, 9'h0FF, -1, 9'h000, 9'h0FF, 5'd2};
        vecs[6] = '{9'h000, 1'b0,  5, 9'h007,  6, 9'h007,  7, 9'h007, 9'h007, 5'd1};

        RESET = 1'b1;
        bus.START = 0; bus.ABORT = 0; bus.WR_REQ = 0; bus.WR_ADDR = '0; bus.WR_DATA = '0;
        host_prev = 0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        repeat (3) @(negedge CLOCK);
        #1;
        check("rst_busy", int'(bus.BUSY), 0);
        check("rst_done", int'(bus.DONE), 0);
        check("rst_valid", int'(bus.VALID), 0);
        check("rst_max", int'(bus.MAX_OUT), 0);
        check("rst_num", int'(bus.NUM_OUT), 0);
        @(negedge CLOCK);
        RESET = 1'b0;

        // Empty memory scan: BUSY 1..32, DONE at 33.
        run_scan(0, 0, 0, 0, cyc);
        #1;
        check("t1_cycles", cyc, 33);
        check("t1_max", int'(bus.MAX_OUT), 0);
        check("t1_num", int'(bus.NUM_OUT), 0);
        check("t1_valid_hold", int'(bus.VALID), 1);

        for (int r = 0; r < 7; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                w = vecs[r].ramp ? 9'(a) : vecs[r].base;
                if (a == vecs[r].a0) w = vecs[r].v0;
                if (a == vecs[r].a1) w = vecs[r].v1;
                if (a == vecs[r].a2) w = vecs[r].v2;
                write_word(5'(a), w);
            end
            run_scan(0, 0, 0, 0, cyc);
            #1;
            check($sformatf("vec%0d_cycles", r), cyc, 33);
            check($sformatf("vec%0d_max", r), int'(bus.MAX_OUT), int'(vecs[r].exp_max));
            check($sformatf("vec%0d_num", r), int'(bus.NUM_OUT), int'(vecs[r].exp_num));
            check($sformatf("vec%0d_valid", r), int'(bus.VALID), 1);
        end

        // Alternating 0/1 with the host requesting every cycle from LOAD on.
        for (int a = 0; a < DEPTH; a++) write_word(5'(a), 9'(a % 2));
        run_scan(100, 1, 0, 0, cyc);
        #1;
        check("alt_cycles", cyc, 65);
        check("alt_max", int'(bus.MAX_OUT), 1);
        check("alt_num", int'(bus.NUM_OUT), 15);

        // Abort at cycle 10.
        @(negedge CLOCK);
        bus.START = 1'b1;
        @(negedge CLOCK);
        bus.START = 1'b0;
        repeat (9) @(negedge CLOCK);
        bus.ABORT = 1'b1;
        #1;
        check("abort_busy_c10", int'(bus.BUSY), 1);
        @(negedge CLOCK);
        bus.ABORT = 1'b0;
        #1;
        check("abort_idle_c11", int'(bus.BUSY), 0);
        check("abort_valid", int'(bus.VALID), 0);
        check("abort_done", int'(bus.DONE), 0);
        check("abort_max_kept", int'(bus.MAX_OUT), 1);
        check("abort_num_kept", int'(bus.NUM_OUT), 15);
        dones = 0;
        repeat (40) begin
            @(negedge CLOCK); #1;
            if (bus.DONE) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_valid_held", int'(bus.VALID), 0);

        // START together with ABORT in IDLE, then back-to-back from DONE.
        @(negedge CLOCK);
        run_scan(0, 0, 1, 1, cyc);
        check("abort_start_cycles", cyc, 33);
        scan_body(30, 0, 0, cyc);

        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                w = ($urandom_range(0, 1) == 1) ? 9'($urandom) : 9'($urandom_range(0, 3)) - 9'd2;
                write_word(5'(a), w);
            end
            run_scan(40, 0, 0, 0, cyc);
        end

        // Reset at cycle 12 of a scan.
        bus.START = 1'b1;
        @(negedge CLOCK);
        bus.START = 1'b0;
        repeat (11) @(negedge CLOCK);
        #1;
        RESET = 1'b1;
        #1;
        check("mid_rst_busy", int'(bus.BUSY), 0);
        check("mid_rst_valid", int'(bus.VALID), 0);
        check("mid_rst_done", int'(bus.DONE), 0);
        check("mid_rst_max", int'(bus.MAX_OUT), 0);
        check("mid_rst_num", int'(bus.NUM_OUT), 0);
        @(negedge CLOCK);
        RESET = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        host_prev = 0;
        run_scan(0, 0, 0, 0, cyc);
        #1;
        check("post_rst_max", int'(bus.MAX_OUT), 0);
        check("post_rst_num", int'(bus.NUM_OUT), 0);
        check("post_rst_cycles", cyc, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/peak_scan_ctrl.md
Name: peak_scan_ctrl

Overview:
Sequencer and arbiter for a peak/maximum scan datapath over a writable sample memory of 2^ADDR_W signed words.
- A host loads samples through a write port.
- A START pulse launches a scan that finds the signed maximum and counts peaks (a rise followed by a fall).
- The single memory port is shared between host writes and scan reads by an alternating-priority arbiter.
- Results feed the display-formatting logic downstream.

Parameters:
ADDR_W, 5, memory address width; DEPTH = 2^ADDR_W (default 32)
DATA_W, 9, sample width, two's complement
NUM_W, 5, peak-count width; saturates at 2^NUM_W-1

Ports:
CLOCK  in  1  rising-edge clock
RESET  in  1  asynchronous, active-high reset
START  in  1  scan request; sampled only in IDLE/DONE
ABORT  in  1  cancel a running scan
WR_REQ  in  1  host write request
WR_ADDR  in  ADDR_W  host write address
WR_DATA  in  DATA_W  host write data
WR_ACK  out  1  combinational grant; the write commits at this edge
BUSY  out  1  high in LOAD/SCAN
DONE  out  1  one-cycle completion pulse
VALID  out  1  MAX_OUT/NUM_OUT hold a completed result
MAX_OUT  out  DATA_W  signed maximum of the last completed scan
NUM_OUT  out  NUM_W  peak count of the last completed scan

Behaviour:
- Reset (asynchronous, any state): state=IDLE. BUSY=DONE=VALID=0. MAX_OUT=0, NUM_OUT=0. All memory words=0. MAR=0, TEMP=0, FLAG=0. Arbiter history="not host".
- States:
  - IDLE -> LOAD on START.
  - LOAD: read addr 0; MAX=TEMP=data; FLAG=0; NUM=0; MAR=1. -> SCAN.
  - SCAN: one address per granted read.
  - After addr DEPTH-1 is processed -> DONE.
  - DONE: DONE=1 and VALID=1 for this cycle; MAX_OUT/NUM_OUT loaded. -> IDLE, or -> LOAD if START is high.
- SCAN compare, with d=mem[MAR], fully signed with no wrap artefacts:
  - d<TEMP: if FLAG then NUM++ (saturating) and FLAG=0.
  - d>TEMP: FLAG=1; if d>MAX then MAX=d.
  - d==TEMP: no change.
  - In all cases TEMP=d, then MAR++.
- Invariant: in SCAN, MAX >= TEMP (signed).
- Latency, no contention: START sampled at edge 0 -> BUSY high in cycles 1..DEPTH; DONE in cycle DEPTH+1 (33 by default).
- Arbitration:
  - In IDLE/DONE, WR_ACK=WR_REQ.
  - In LOAD/SCAN, when WR_REQ=1: host wins if the previous cycle's port owner was not the host. Otherwise the scan wins.
  - A losing scan stalls: no state, MAR, or datapath update.
  - Worst case is one write per two cycles; the scan is never starved longer than 1 cycle.
- Coherence: the result reflects each address's content at the cycle it is read. A write to an already-scanned address does not affect the current result.
- START while BUSY: ignored.
- ABORT while BUSY: next state IDLE; VALID=0; no DONE pulse. MAX_OUT/NUM_OUT keep old values. ABORT outside BUSY has no effect.
- ABORT and START in the same IDLE cycle: START wins, because ABORT is ignored outside BUSY.
- VALID stays 1 from DONE until the next LOAD, ABORT, or RESET. LOAD clears VALID.
- RESET mid-scan: immediate IDLE; memory cleared.

Decomposition:
- Package peak_scan_pkg holds:
  - the state enum (IDLE, LOAD, SCAN, DONE);
  - default widths;
  - a signed-compare helper function.
- One sub-module, scan_mem: DEPTH x DATA_W register file with a single port, asynchronous read, synchronous write, and asynchronous clear on RESET.
- Arbiter and FSM live in peak_scan_ctrl.

Test Plan:
1. RESET, then START pulse with no writes -> BUSY cycles 1..32, DONE at cycle 33, MAX_OUT=0, NUM_OUT=0, VALID=1.
2. Write mem[0]=5, mem[1]=10, mem[2]=3, rest 0; START -> MAX_OUT=10, NUM_OUT=1.
3. All words 9'h1F9 (-7) except mem[4]=9'h1FE (-2); START -> MAX_OUT=9'h1FE, NUM_OUT=1. Check 9'h0FF is never reported.
4. Even addr=0, odd addr=1; START with WR_REQ held high throughout, writing addr 0 with value 0 -> WR_ACK alternates (host first in LOAD), DONE at cycle 65, NUM_OUT=15, MAX_OUT=1.
5. START, ABORT at cycle 10 -> IDLE at cycle 11, no DONE, VALID=0, MAX_OUT/NUM_OUT unchanged. Second START completes normally.
6. RESET asserted mid-scan (cycle 12) -> outputs 0 asynchronously, memory reads 0. Post-reset scan gives MAX_OUT=0, NUM_OUT=0.
